// File: rtl/riscv16_pkg.sv
// riscv16_pkg: shared widths, instruction field positions and opcodes of the 16-bit core
package riscv16_pkg;
  localparam int REG_W = 3;
  localparam int DATA_W = 16;
  localparam int NREGS = 1 << REG_W;
  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int RD_HI = 11;
  localparam int RD_LO = 9;
  localparam int RS1_HI = 8;
  localparam int RS1_LO = 6;
  localparam int RS2_HI = 5;
  localparam int RS2_LO = 3;
  localparam int IMM6_HI = 5;
  localparam int IMM9_HI = 8;
  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SLT  = 4'h5,
    OP_SLL  = 4'h6,
    OP_SRL  = 4'h7,
    OP_ADDI = 4'h8,
    OP_LW   = 4'h9,
    OP_SW   = 4'hA,
    OP_BEQ  = 4'hB,
    OP_JAL  = 4'hC
  } opcode_e;
  function automatic logic [DATA_W-1:0] sext6(input logic [IMM6_HI:0] v);
    return {{(DATA_W-IMM6_HI-1){v[IMM6_HI]}}, v};
  endfunction
  function automatic logic [DATA_W-1:0] sext9(input logic [IMM9_HI:0] v);
    return {{(DATA_W-IMM9_HI-1){v[IMM9_HI]}}, v};
  endfunction
endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: combinational field extraction, source/dest usage and immediate generation
module instr_decoder
  import riscv16_pkg::*;
(
  input  logic [DATA_W-1:0] i_instr,
  output logic [REG_W-1:0]  o_rs1,
  output logic [REG_W-1:0]  o_rs2,
  output logic [REG_W-1:0]  o_rd,
  output logic              o_use_rs1,
  output logic              o_use_rs2,
  output logic              o_writes_rd,
  output logic [DATA_W-1:0] o_imm,
  output logic              o_illegal
);
  logic [3:0] w_op;
  logic       w_rtype;
  logic       w_store_br;
  assign w_op = i_instr[OP_HI:OP_LO];
  assign w_rtype = w_op <= OP_SRL;
  assign w_store_br = w_op == OP_SW || w_op == OP_BEQ;
  always_comb begin
    o_use_rs1 = w_op < OP_JAL;
    o_use_rs2 = w_rtype || w_store_br;
    o_writes_rd = w_op < OP_SW || w_op == OP_JAL;
    o_illegal = w_op > OP_JAL;
    o_rd = i_instr[RD_HI:RD_LO];
    o_rs1 = o_use_rs1 ? i_instr[RS1_HI:RS1_LO] : '0;
    // stores and branches carry their second source in the rd field
    o_rs2 = w_rtype ? i_instr[RS2_HI:RS2_LO] : w_store_br ? i_instr[RD_HI:RD_LO] : '0;
    o_imm = (w_op >= OP_ADDI && w_op <= OP_BEQ) ? sext6(i_instr[IMM6_HI:0]) :
            w_op == OP_JAL ? sext9(i_instr[IMM9_HI:0]) : '0;
  end
endmodule

// File: rtl/decode_issue_stage.sv
// decode_issue_stage: decode, busy scoreboard, writeback bypass and single-entry issue register
module decode_issue_stage
  import riscv16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_pc,
  output logic [REG_W-1:0]  rs1,
  output logic [REG_W-1:0]  rs2,
  input  logic [DATA_W-1:0] rd1,
  input  logic [DATA_W-1:0] rd2,
  input  logic              wb_we,
  input  logic [REG_W-1:0]  wb_ws,
  input  logic [DATA_W-1:0] wb_wd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_op,
  output logic [REG_W-1:0]  out_ws,
  output logic              out_we,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_pc,
  output logic              out_illegal
);
  logic [REG_W-1:0]  w_rs1, w_rs2, w_rd;
  logic              w_use1, w_use2, w_we, w_ill;
  logic [DATA_W-1:0] w_imm, w_a, w_b;
  logic [NREGS-1:0]  w_wb_mask, w_busy_eff, w_rel_mask, w_set_mask, w_busy_nxt;
  logic              w_hazard, w_issue;
  logic [NREGS-1:0]  r_busy;
  logic              r_valid, r_we, r_ill;
  logic [3:0]        r_op;
  logic [REG_W-1:0]  r_ws;
  logic [DATA_W-1:0] r_a, r_b, r_imm, r_pc;
  instr_decoder u_dec (
    .i_instr    (in_instr),
    .o_rs1      (w_rs1),
    .o_rs2      (w_rs2),
    .o_rd       (w_rd),
    .o_use_rs1  (w_use1),
    .o_use_rs2  (w_use2),
    .o_writes_rd(w_we),
    .o_imm      (w_imm),
    .o_illegal  (w_ill)
  );
  assign rs1 = w_rs1;
  assign rs2 = w_rs2;
  always_comb begin
    w_wb_mask = wb_we ? NREGS'(1) << wb_ws : '0;
    // a register being written back this cycle is already available via the bypass
    w_busy_eff = r_busy & ~w_wb_mask;
    w_hazard = (w_use1 && w_busy_eff[w_rs1]) || (w_use2 && w_busy_eff[w_rs2]) || (w_we && w_busy_eff[w_rd]);
    in_ready = !rst && !flush && !w_hazard && (!r_valid || out_ready);
    w_issue = in_valid && in_ready;
    w_a = !w_use1 ? '0 : (wb_we && wb_ws == w_rs1) ? wb_wd : rd1;
    w_b = !w_use2 ? '0 : (wb_we && wb_ws == w_rs2) ? wb_wd : rd2;
    // a flushed instruction that execute never took will never write back
    w_rel_mask = (flush && r_valid && r_we && !out_ready) ? NREGS'(1) << r_ws : '0;
    w_set_mask = (w_issue && w_we) ? NREGS'(1) << w_rd : '0;
    w_busy_nxt = (r_busy & ~w_wb_mask & ~w_rel_mask) | w_set_mask;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
      r_valid <= 1'b0;
      r_op <= '0;
      r_ws <= '0;
      r_we <= 1'b0;
      r_a <= '0;
      r_b <= '0;
      r_imm <= '0;
      r_pc <= '0;
      r_ill <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_issue) begin
        r_valid <= 1'b1;
        r_op <= in_instr[OP_HI:OP_LO];
        r_ws <= w_we ? w_rd : '0;
        r_we <= w_we;
        r_a <= w_a;
        r_b <= w_b;
        r_imm <= w_imm;
        r_pc <= in_pc;
        r_ill <= w_ill;
      end else if (flush || out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end
  assign out_valid = r_valid;
  assign out_op = r_op;
  assign out_ws = r_ws;
  assign out_we = r_we;
  assign out_a = r_a;
  assign out_b = r_b;
  assign out_imm = r_imm;
  assign out_pc = r_pc;
  assign out_illegal = r_ill;
endmodule

// File: tb/tb_decode_issue_stage.sv
// tb_decode_issue_stage: randomized and directed stimulus against a queue-based reference model
module tb_decode_issue_stage;
  logic        clk = 0, rst = 1;
  logic        in_valid = 0, in_ready;
  logic [15:0] in_instr = 0, in_pc = 0;
  logic [2:0]  rs1, rs2;
  logic [15:0] rd1, rd2;
  logic        wb_we = 0;
  logic [2:0]  wb_ws = 0;
  logic [15:0] wb_wd = 0;
  logic        flush = 0, out_valid, out_ready = 0;
  logic [3:0]  out_op;
  logic [2:0]  out_ws;
  logic        out_we, out_illegal;
  logic [15:0] out_a, out_b, out_imm, out_pc;

  always #5 clk = ~clk;

  decode_issue_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2), .wb_we(wb_we), .wb_ws(wb_ws),
    .wb_wd(wb_wd), .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_ws(out_ws), .out_we(out_we), .out_a(out_a), .out_b(out_b), .out_imm(out_imm),
    .out_pc(out_pc), .out_illegal(out_illegal)
  );

  logic [15:0] regs [8];
  assign rd1 = regs[rs1];
  assign rd2 = regs[rs2];
  always @(posedge clk) if (wb_we) regs[wb_ws] <= wb_wd;

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  ws;
    logic        we;
    logic [15:0] a, b, imm, pc;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   pend[$];
  bit   mbusy[8];
  bit   last_rst = 1;
  int   n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] enc(input int op, input int d, input int a, input int b);
    return {4'(op), 3'(d), 3'(a), 3'(b), 3'b000};
  endfunction

  task automatic step(input bit v, input logic [15:0] ins, input bit ordy, input bit fl,
                      input bit wbe, input logic [2:0] wbs, input logic [15:0] wbd, input bit r);
    int op;
    bit u1, u2, w, hz, er, held, iss;
    logic [2:0] s1, s2, d;
    logic [15:0] imm, va, vb;
    exp_t f;
    @(negedge clk);
    in_valid = v; in_instr = ins; in_pc = 16'($urandom); out_ready = ordy; flush = fl;
    wb_we = wbe; wb_ws = wbs; wb_wd = wbd; rst = r;
    #1;
    op = int'(ins[15:12]);
    u1 = op < 12;
    u2 = op < 8 || op == 10 || op == 11;
    w = op < 10 || op == 12;
    s1 = ins[8:6];
    s2 = op < 8 ? ins[5:3] : ins[11:9];
    d = ins[11:9];
    imm = (op >= 8 && op <= 11) ? {{10{ins[5]}}, ins[5:0]} : op == 12 ? {{7{ins[8]}}, ins[8:0]} : 16'h0;
    hz = (u1 && mbusy[s1] && !(wbe && wbs == s1)) || (u2 && mbusy[s2] && !(wbe && wbs == s2)) ||
         (w && mbusy[d] && !(wbe && wbs == d));
    held = exp_q.size() != 0;
    er = !r && !fl && !hz && (!held || ordy);
    chk("in_ready", 16'(in_ready), 16'(er));
    chk("rs1", 16'(rs1), u1 ? 16'(s1) : 16'h0);
    chk("rs2", 16'(rs2), u2 ? 16'(s2) : 16'h0);
    iss = v && er;
    va = !u1 ? 16'h0 : (wbe && wbs == s1) ? wbd : regs[s1];
    vb = !u2 ? 16'h0 : (wbe && wbs == s2) ? wbd : regs[s2];
    if (r) begin
      exp_q.delete();
      pend.delete();
      foreach (mbusy[i]) mbusy[i] = 0;
    end else begin
      if (wbe) mbusy[wbs] = 0;
      if (held && (ordy || fl)) begin
        f = exp_q.pop_front();
        if (ordy && f.we) pend.push_back(int'(f.ws));
        else if (!ordy && f.we) mbusy[f.ws] = 0;
      end
      if (iss) begin
        if (w) mbusy[d] = 1;
        exp_q.push_back('{op: 4'(op), ws: w ? d : 3'd0, we: w, a: va, b: vb, imm: imm, pc: in_pc, ill: op > 12});
      end
    end
    last_rst = r;
  endtask

  task automatic pick_wb(output bit e, output logic [2:0] s, output logic [15:0] d);
    int k;
    e = 0;
    s = 3'($urandom);
    d = 16'($urandom);
    if (pend.size() != 0 && $urandom % 2 == 0) begin
      k = int'($urandom % pend.size());
      s = 3'(pend[k]);
      pend.delete(k);
      e = 1;
    end else if ($urandom % 6 == 0) e = 1;
  endtask

  task automatic drain();
    logic [2:0] s;
    bit e;
    for (int i = 0; i < 40 && (exp_q.size() != 0 || pend.size() != 0); i++) begin
      e = pend.size() != 0;
      s = e ? 3'(pend.pop_front()) : 3'd0;
      step(0, 16'h0, 1, 0, e, s, 16'($urandom), 0);
    end
    chk("drain_left", 16'(exp_q.size() + pend.size()), 16'h0);
  endtask

  always @(posedge clk) begin
    #2;
    chk("out_valid", 16'(out_valid), 16'(exp_q.size() != 0));
    if (last_rst) begin
      chk("rst_op", 16'(out_op), 16'h0);
      chk("rst_ws_we_ill", {11'h0, out_ws, out_we, out_illegal}, 16'h0);
      chk("rst_a", out_a, 16'h0);
      chk("rst_b", out_b, 16'h0);
      chk("rst_imm", out_imm, 16'h0);
      chk("rst_pc", out_pc, 16'h0);
    end else if (exp_q.size() != 0 && out_valid) begin
      chk("out_op", 16'(out_op), 16'(exp_q[0].op));
      chk("out_ws", 16'(out_ws), 16'(exp_q[0].ws));
      chk("out_we", 16'(out_we), 16'(exp_q[0].we));
      chk("out_a", out_a, exp_q[0].a);
      chk("out_b", out_b, exp_q[0].b);
      chk("out_imm", out_imm, exp_q[0].imm);
      chk("out_pc", out_pc, exp_q[0].pc);
      chk("out_illegal", 16'(out_illegal), 16'(exp_q[0].ill));
    end
  end

  initial begin
    bit e, v, fl, r;
    logic [2:0] s;
    logic [15:0] d;
    foreach (regs[i]) regs[i] = 16'($urandom);
    regs[1] = 16'd5;
    regs[2] = 16'd7;
    repeat (3) step(0, 16'h0, 1, 0, 0, 0, 0, 1);
    step(1, enc(0, 3, 1, 2), 1, 0, 0, 0, 0, 0);
    step(1, enc(0, 4, 3, 3), 1, 0, 0, 0, 0, 0);
    drain();
    step(1, {4'h8, 3'd2, 3'd2, 6'h3F}, 1, 0, 0, 0, 0, 0);
    step(1, enc(0, 4, 2, 2), 1, 0, 0, 0, 0, 0);
    step(1, enc(0, 4, 2, 2), 1, 0, 0, 0, 0, 0);
    step(1, enc(0, 4, 2, 2), 1, 0, 1, 3'd2, 16'h0009, 0);
    drain();
    step(1, enc(0, 5, 1, 1), 0, 0, 0, 0, 0, 0);
    repeat (3) step(1, enc(1, 6, 1, 1), 0, 0, 0, 0, 0, 0);
    step(1, enc(1, 6, 1, 1), 1, 0, 0, 0, 0, 0);
    drain();
    step(1, {4'h9, 3'd5, 3'd1, 6'h02}, 1, 0, 0, 0, 0, 0);
    step(1, {4'hC, 3'd5, 9'h1F0}, 1, 0, 0, 0, 0, 0);
    step(1, {4'hC, 3'd5, 9'h1F0}, 1, 0, 0, 0, 0, 0);
    step(1, {4'hC, 3'd5, 9'h1F0}, 1, 0, 1, 3'd5, 16'h1234, 0);
    drain();
    step(1, {4'h8, 3'd6, 3'd1, 6'h01}, 0, 0, 0, 0, 0, 0);
    step(0, 16'h0, 0, 0, 0, 0, 0, 0);
    step(0, 16'h0, 0, 1, 0, 0, 0, 0);
    step(1, enc(0, 7, 6, 6), 1, 0, 0, 0, 0, 0);
    drain();
    step(1, {4'h8, 3'd6, 3'd1, 6'h01}, 1, 0, 1, 3'd6, 16'h00AA, 0);
    step(1, enc(0, 7, 6, 6), 1, 0, 0, 0, 0, 0);
    drain();
    step(1, {4'h9, 3'd3, 3'd1, 6'h00}, 1, 0, 0, 0, 0, 0);
    step(1, enc(14, 3, 3, 3), 1, 0, 0, 0, 0, 0);
    drain();
    step(1, {4'h9, 3'd1, 3'd2, 6'h00}, 1, 0, 0, 0, 0, 0);
    step(1, enc(0, 2, 1, 1), 1, 0, 0, 0, 0, 0);
    step(1, enc(0, 2, 1, 1), 0, 0, 0, 0, 0, 1);
    step(1, enc(0, 2, 1, 1), 1, 0, 0, 0, 0, 0);
    drain();
    repeat (3000) begin
      pick_wb(e, s, d);
      v = $urandom % 4 != 0;
      fl = $urandom % 20 == 0;
      r = $urandom % 100 == 0;
      step(v, 16'($urandom), $urandom % 10 < 7, fl, e, s, d, r);
    end
    drain();
    step(0, 16'h0, 1, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/decode_issue_stage.md
# decode_issue_stage

Decode-and-issue stage of the 16-bit processor, directly upstream of `register_file` and downstream of fetch. It accepts one 16-bit instruction per cycle under a valid/ready handshake, decodes its fields, drives `rs1`/`rs2` into the register file, and captures the operands into a single output pipeline register for execute. An 8-bit busy scoreboard stalls issue on RAW and WAW hazards until the matching writeback is seen. Same-cycle writeback values are bypassed around the register file.

## Interface
- No parameters. Widths are fixed: 16-bit data, 3-bit register index, 8 registers.
- One clock; reset is synchronous and active-high.
- `clk  in  1`  rising-edge clock.
- `rst  in  1`  synchronous active-high reset.
- `in_valid  in  1`  fetch holds a valid instruction.
- `in_ready  out  1`  the stage accepts the instruction this cycle.
- `in_instr  in  16`  instruction word.
- `in_pc  in  16`  PC of `in_instr`.
- `rs1, rs2  out  3`  read addresses to `register_file`.
- `rd1, rd2  in  16`  combinational read data from `register_file`.
- `wb_we, wb_ws, wb_wd  in  1/3/16`  the writeback port, observed here in parallel with `register_file` `we`/`ws`/`wd`.
- `flush  in  1`  kill the held output, for example on a taken branch.
- `out_valid  in/out: out  1`  the output register holds an issued instruction.
- `out_ready  in  1`  execute consumes the held instruction this cycle.
- `out_op  out  4`  opcode.
- `out_ws  out  3`  destination register.
- `out_we  out  1`  the instruction writes `out_ws`.
- `out_a, out_b  out  16`  source operands.
- `out_imm  out  16`  sign-extended immediate.
- `out_pc  out  16`  PC of the held instruction.
- `out_illegal  out  1`  the opcode is undefined.

## Operation
- Instruction fields:
  - opcode `[15:12]`
  - rd `[11:9]`
  - rs1 `[8:6]`
  - rs2 `[5:3]`
  - imm6 `[5:0]`
  - imm9 `[8:0]`
- Opcodes:
  - 0–7 (ADD, SUB, AND, OR, XOR, SLT, SLL, SRL): R-type. Reads rs1 and rs2, writes rd.
  - 8 ADDI and 9 LW: read rs1, write rd, imm = sext(imm6).
  - A SW and B BEQ: read rs1 and rs2, where the rs2 index comes from `[11:9]`. No write. imm = sext(imm6).
  - C JAL: no reads, writes rd, imm = sext(imm9).
  - D–F: illegal. No reads, no write, `out_illegal`=1, passed downstream.
- Unused source indices are driven to 0 and never cause a stall.
- All 8 registers are writable; r0 is not special.
- Operand bypass: if `wb_we` and `wb_ws`==index, the operand is `wb_wd`; otherwise it is `rd1`/`rd2`.
- Scoreboard `busy[7:0]`:
  - Hazard = a used source is busy, or the instruction writes and `busy[rd]` is set.
  - A busy bit whose `wb_ws` is being written this cycle counts as clear for the hazard check.
- Handshake:
  - `in_ready = !rst && !flush && !hazard && (!out_valid || out_ready)`.
  - Issue = `in_valid && in_ready`.
  - `in_ready` may depend combinationally on `in_instr`.
- On issue: load all `out_*`, set `out_valid`=1, and set `busy[rd]` if the instruction writes.
- With no issue, `out_valid && out_ready` clears `out_valid`.
- Each cycle `wb_we` clears `busy[wb_ws]`. If an issue sets the same bit in the same cycle, set wins.
- Flush:
  - Clears `out_valid`; nothing issues that cycle.
  - If the held instruction has `out_we`=1 and is not accepted (`!out_ready`) that cycle, its `busy[out_ws]` is released.
  - An accepted one stays busy; it belongs to execute.
- Reset: all `out_*` = 0, `out_valid` = 0, `busy` = 0. `in_ready` = 0 during reset. Reset mid-stall discards everything.

## Timing
- Issue-to-`out_valid` latency: 1 cycle.
- Throughput: 1 instruction per cycle when hazard-free and `out_ready`=1.
- Operands are sampled on the issue edge; `register_file` is read combinationally the same cycle.
- Writeback on cycle N unblocks a dependent instruction on cycle N through the bypass, so the earliest issue is cycle N.
- The held output is stable while `out_valid && !out_ready`.

## Structure
- Shared package `riscv16_pkg`:
  - opcode constants
  - field bit positions
  - `REG_W`=3, `DATA_W`=16
- Sub-module `instr_decoder` (combinational) outputs: rs1 index, rs2 index, use_rs1, use_rs2, writes_rd, imm, illegal.
- This block holds the scoreboard, bypass, handshake and output register.

## Test plan
- Reset, then ADD r3,r1,r2 with r1=5, r2=7 and `out_ready`=1 → next cycle `out_valid`=1, `out_a`=5, `out_b`=7, `out_ws`=3, `busy[3]`=1.
- ADDI r2,r2,-1 (imm6=0x3F) followed by ADD r4,r2,r2 → the second instruction stalls (`in_ready`=0). When writeback r2=0x0009 arrives, it issues that same cycle with `out_a`=`out_b`=0x0009.
- Back-to-back independent instructions with `out_ready`=0 for 3 cycles → the output is held stable and `in_ready`=0. The next instruction issues in the cycle `out_ready` returns to 1.
- WAW: LW r5 issued, then JAL r5 with imm9=0x1F0 → stalls until `wb_ws`=5. After that, `out_imm`=0xFFF0.
- Flush while holding an unaccepted ADDI r6 → `out_valid`=0 next cycle and `busy[6]`=0. An issue and `wb_we` to r6 in the same cycle leave `busy[6]`=1.
- Opcode 0xE → `out_illegal`=1, `out_we`=0, never stalls. Asserting `rst` mid-stall → all outputs and `busy` are 0 on the next cycle.
